// File: rtl/nios2_subsystem_pio_pkg.sv
// Shared definitions for the Nios II subsystem strobe PIO: register map,
// STATUS bit positions and the burst sequencer state encoding.
package nios2_subsystem_pio_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
    localparam logic [2:0] ADDR_PULSE  = 3'd3;
    localparam logic [2:0] ADDR_BURST  = 3'd4;
    localparam logic [2:0] ADDR_GAP    = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } burst_state_t;

endpackage

// File: rtl/nios2_subsystem_pio_burst_seq.sv
// Burst sequencer: emits `count` single-cycle pulses separated by `gap` idle
// cycles, tracks pulses still outstanding and flags completion.
module nios2_subsystem_pio_burst_seq
    import nios2_subsystem_pio_pkg::*;
#(
    parameter int unsigned COUNT_W = 16,
    parameter int unsigned GAP_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [COUNT_W-1:0] count,
    input  logic [GAP_W-1:0]   gap,
    input  logic               clear_done,
    output logic               burst_strobe,
    output logic               busy,
    output logic [COUNT_W-1:0] remaining,
    output logic               done
);

    burst_state_t     state;
    logic [GAP_W-1:0] gcnt;

    // Burst FSM with counters; outputs are registered alongside the state.
    // A load overrides the natural transition; completion beats a done-clear
    // landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            gcnt         <= '0;
            done         <= 1'b0;
            burst_strobe <= 1'b0;
            busy         <= 1'b0;
        end else if (load) begin
            if (count != '0) begin
                state        <= PULSE;
                remaining    <= count;
                done         <= 1'b0;
                burst_strobe <= 1'b1;
                busy         <= 1'b1;
            end else begin
                state        <= IDLE;
                remaining    <= '0;
                burst_strobe <= 1'b0;
                busy         <= 1'b0;
            end
        end else begin
            if (clear_done) begin
                done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    burst_strobe <= 1'b0;
                    busy         <= 1'b0;
                end
                PULSE: begin
                    remaining <= remaining - COUNT_W'(1);
                    if (remaining == COUNT_W'(1)) begin
                        state        <= IDLE;
                        done         <= 1'b1;
                        burst_strobe <= 1'b0;
                        busy         <= 1'b0;
                    end else if (gap == '0) begin
                        state        <= PULSE;
                        burst_strobe <= 1'b1;
                        busy         <= 1'b1;
                    end else begin
                        state        <= GAP;
                        gcnt         <= gap;
                        burst_strobe <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                GAP: begin
                    gcnt <= gcnt - GAP_W'(1);
                    busy <= 1'b1;
                    if (gcnt == GAP_W'(1)) begin
                        state        <= PULSE;
                        burst_strobe <= 1'b1;
                    end else begin
                        burst_strobe <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    burst_strobe <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/nios2_subsystem_pio_strobe.sv
// Avalon-MM output PIO: level outputs with atomic set/clear, one-cycle strobe
// lanes and a hardware read-request burst sequencer.
module nios2_subsystem_pio_strobe
    import nios2_subsystem_pio_pkg::*;
#(
    parameter int unsigned     WIDTH       = 8,
    parameter int unsigned     COUNT_W     = 16,
    parameter int unsigned     GAP_W       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] strobe_port,
    output logic             burst_strobe,
    output logic             busy
);

    logic               wr;
    logic [WIDTH-1:0]   wd_lane;
    logic [GAP_W-1:0]   gap_reg;
    logic [COUNT_W-1:0] remaining;
    logic               done;
    logic               unused_writedata;

    assign wr               = chipselect & ~write_n;
    assign wd_lane          = writedata[WIDTH-1:0];
    assign unused_writedata = &{1'b0, writedata};

    // Level, strobe and gap registers; strobes self-clear after one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_port    <= RESET_VALUE;
            strobe_port <= '0;
            gap_reg     <= '0;
        end else begin
            strobe_port <= (wr && address == ADDR_PULSE) ? wd_lane : '0;
            if (wr) begin
                case (address)
                    ADDR_DATA: out_port <= wd_lane;
                    ADDR_SET:  out_port <= out_port | wd_lane;
                    ADDR_CLR:  out_port <= out_port & ~wd_lane;
                    ADDR_GAP:  gap_reg  <= writedata[GAP_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    nios2_subsystem_pio_burst_seq #(
        .COUNT_W (COUNT_W),
        .GAP_W   (GAP_W)
    ) u_burst_seq (
        .clk          (clk),
        .reset        (reset),
        .load         (wr && address == ADDR_BURST),
        .count        (writedata[COUNT_W-1:0]),
        .gap          (gap_reg),
        .clear_done   (wr && address == ADDR_STATUS && writedata[STATUS_DONE_BIT]),
        .burst_strobe (burst_strobe),
        .busy         (busy),
        .remaining    (remaining),
        .done         (done)
    );

    // Combinational read mux, zero-extended, no wait states.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0]   = out_port;
            ADDR_BURST:  readdata[COUNT_W-1:0] = remaining;
            ADDR_GAP:    readdata[GAP_W-1:0]   = gap_reg;
            ADDR_STATUS: begin
                readdata[STATUS_DONE_BIT] = done;
                readdata[STATUS_BUSY_BIT] = busy;
            end
            default: ;
        endcase
    end

endmodule
